// File: rtl/mii_pkg.sv
// Shared types and constants for the MII receive framer.
package mii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } mii_state_e;

    localparam logic [3:0]  MII_PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  MII_SFD_NIBBLE      = 4'hD;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // The reflected CRC register holds the residue bit-reversed.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/mii_rx_framer_if.sv
// MII receive pins plus the outgoing byte stream. slave = framer, master = PHY/sink side.
interface mii_rx_framer_if;
    logic       rx_dv;
    logic       rx_er;
    logic [3:0] rxd;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tuser;

    // Stream has no ready: m_tvalid is a one-cycle strobe that must be taken when offered;
    // m_tlast marks the final byte and m_tuser is only meaningful together with m_tlast.
    modport slave  (input  rx_dv, rx_er, rxd,
                    output m_tdata, m_tvalid, m_tlast, m_tuser);
    modport master (output rx_dv, rx_er, rxd,
                    input  m_tdata, m_tvalid, m_tlast, m_tuser);
endinterface

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB first).
module crc32_d8
    import mii_pkg::*;
(
    input  logic [7:0]  data_i,
    input  logic [31:0] crc_i,
    output logic [31:0] crc_o
);
    localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) c = (c >> 1) ^ POLY_REFL;
            else                  c = c >> 1;
        end
        crc_o = c;
    end
endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into a one-byte-delayed byte stream.
// Optional FCS check enabled by defining MII_RX_FCS_CHECK_EN.
module mii_rx_framer
    import mii_pkg::*;
#(
    parameter int MAX_FRAME_BYTES      = 1522,
    parameter int PREAMBLE_MIN_NIBBLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mii_rx_framer_if.slave  bus,
    output mii_state_e      state_o
);
    localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN_NIBBLES);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME_BYTES);

    mii_state_e  state_q, state_d;
    logic        armed_q;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  lo_nib_q, lo_nib_d;
    logic        odd_q, odd_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        err_q, err_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [7:0]  new_byte;
    logic        fcs_bad;

    assign new_byte = {bus.rxd, lo_nib_q};

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        lo_nib_d   = lo_nib_q;
        odd_d      = odd_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = err_q;
        tdata_d    = tdata_q;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.rx_dv) begin
                // Seeing rx_dv already high on the first edge out of reset means we joined mid-frame.
                if (armed_q && bus.rxd == MII_PREAMBLE_NIBBLE) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = 4'd1;
                end else begin
                    state_d = DROP;
                end
            end
            PREAMBLE: begin
                if (!bus.rx_dv)                        state_d = IDLE;
                else if (bus.rx_er)                    state_d = DROP;
                else if (bus.rxd == MII_PREAMBLE_NIBBLE) begin
                    if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (bus.rxd == MII_SFD_NIBBLE && pre_cnt_q >= PRE_MIN) begin
                    state_d    = DATA;
                    odd_d      = 1'b0;
                    hold_vld_d = 1'b0;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                end else                               state_d = DROP;
            end
            DATA: begin
                if (!bus.rx_dv) begin
                    state_d    = IDLE;
                    hold_vld_d = 1'b0;
                    odd_d      = 1'b0;
                    if (hold_vld_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = hold_q;
                        tlast_d  = 1'b1;
                        tuser_d  = err_q | odd_q | fcs_bad;
                    end
                end else begin
                    if (bus.rx_er) err_d = 1'b1;
                    if (!odd_q) begin
                        lo_nib_d = bus.rxd;
                        odd_d    = 1'b1;
                    end else begin
                        odd_d = 1'b0;
                        if (byte_cnt_q == MAX_CNT) begin
                            // Oversize: close the frame on the held byte and drop the rest.
                            state_d    = DROP;
                            hold_vld_d = 1'b0;
                            if (hold_vld_q) begin
                                tvalid_d = 1'b1;
                                tdata_d  = hold_q;
                                tlast_d  = 1'b1;
                                tuser_d  = 1'b1;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 11'd1;
                            hold_d     = new_byte;
                            hold_vld_d = 1'b1;
                            if (hold_vld_q) begin
                                tvalid_d = 1'b1;
                                tdata_d  = hold_q;
                            end
                        end
                    end
                end
            end
            DROP: if (!bus.rx_dv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            pre_cnt_q  <= '0;
            lo_nib_q   <= '0;
            odd_q      <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            pre_cnt_q  <= pre_cnt_d;
            lo_nib_q   <= lo_nib_d;
            odd_q      <= odd_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
        end
    end

`ifdef MII_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_nxt;
    logic        data_start, byte_accept;

    assign data_start  = (state_q == PREAMBLE) && (state_d == DATA);
    assign byte_accept = (state_q == DATA) && bus.rx_dv && odd_q && (byte_cnt_q != MAX_CNT);

    crc32_d8 u_crc (.data_i(new_byte), .crc_i(crc_q), .crc_o(crc_nxt));

    always_comb begin
        crc_d = crc_q;
        if (data_start)       crc_d = CRC32_INIT;
        else if (byte_accept) crc_d = crc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign fcs_bad = (bitrev32(crc_q) != CRC32_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    assign bus.m_tdata  = tdata_q;
    assign bus.m_tvalid = tvalid_q;
    assign bus.m_tlast  = tlast_q;
    assign bus.m_tuser  = tuser_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer with an expected-byte queue checked by an output monitor.
module tb_mii_rx_framer;
    import mii_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    mii_state_e state;
    mii_rx_framer_if bus();

    mii_rx_framer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state));

    always #5 clk = ~clk;

    // Expected entries are {last, user, data}.
    logic [9:0] exp_q[$];
    logic [7:0] frm[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] want;
        if (bus.m_tvalid === 1'b1) begin
            got = {bus.m_tlast, bus.m_tuser, bus.m_tdata};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_byte: got last=%b user=%b data=%h, expected no output",
                         got[9], got[8], got[7:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL stream_byte: got last=%b user=%b data=%h, expected last=%b user=%b data=%h",
                             got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
                end
            end
        end
    end

    task automatic send_nib(input logic dv, input logic er, input logic [3:0] d);
        bus.rx_dv = dv;
        bus.rx_er = er;
        bus.rxd   = d;
        @(posedge clk);
        #1;
    endtask

    // Sends pre preamble nibbles, SFD, frm[] and an optional trailing nibble, then one idle cycle.
    task automatic send_frame(input int pre, input int er_idx, input bit odd_tail,
                              input bit exp_emit, input bit exp_user);
        int n = frm.size();
        if (exp_emit)
            for (int i = 0; i < n; i++)
                exp_q.push_back({(i == n-1), (i == n-1) && exp_user, frm[i]});
        for (int p = 0; p < pre; p++) send_nib(1'b1, 1'b0, 4'h5);
        send_nib(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < n; i++) begin
            send_nib(1'b1, (er_idx == i), frm[i][3:0]);
            send_nib(1'b1, (er_idx == i), frm[i][7:4]);
        end
        if (odd_tail) send_nib(1'b1, 1'b0, 4'h9);
        send_nib(1'b0, 1'b0, 4'h0);
    endtask

    function automatic logic [31:0] fcs_of_frm();
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < frm.size(); i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ frm[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    task automatic build_fcs_frame(input int seed);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i * 7 + seed));
        f = fcs_of_frm();
        frm.push_back(f[7:0]);
        frm.push_back(f[15:8]);
        frm.push_back(f[23:16]);
        frm.push_back(f[31:24]);
    endtask

    initial begin
        bit flip_user;
`ifdef MII_RX_FCS_CHECK_EN
        flip_user = 1'b1;
`else
        flip_user = 1'b0;
`endif
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        bus.rxd   = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_tdata",  {24'd0, bus.m_tdata}, 32'h0);
        check("reset_tvalid", {31'd0, bus.m_tvalid}, 32'h0);
        check("reset_tlast",  {31'd0, bus.m_tlast}, 32'h0);
        check("reset_tuser",  {31'd0, bus.m_tuser}, 32'h0);
        check("reset_state",  {30'd0, state}, {30'd0, IDLE});
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_nib(1'b0, 1'b0, 4'h0);

        // Basic frame: 7x55 + D5, bytes 01 02 03.
        frm = '{8'h01, 8'h02, 8'h03};
        send_frame(15, -1, 1'b0, 1'b1, 1'b0);

        // Preamble too short: nothing emitted.
        frm = '{8'hAA, 8'hBB};
        send_frame(1, -1, 1'b0, 1'b0, 1'b0);

        // Zero-byte frame after a valid SFD: nothing emitted.
        frm.delete();
        send_frame(4, -1, 1'b0, 1'b0, 1'b0);

        // rx_er during second byte of four.
        frm = '{8'h10, 8'h21, 8'h32, 8'h43};
        send_frame(6, 1, 1'b0, 1'b1, 1'b1);

        // Two bytes plus a dangling nibble.
        frm = '{8'hC3, 8'h5A};
        send_frame(2, -1, 1'b1, 1'b1, 1'b1);

        // Oversize: 1600 bytes in, 1522 out, last one flagged.
        frm.delete();
        for (int i = 0; i < 1600; i++) frm.push_back(8'(i));
        for (int i = 0; i < 1522; i++)
            exp_q.push_back({(i == 1521), (i == 1521), 8'(i)});
        send_frame(14, -1, 1'b0, 1'b0, 1'b0);

        // Two good 64-byte frames separated by one idle cycle.
        build_fcs_frame(3);
        send_frame(15, -1, 1'b0, 1'b1, 1'b0);
        build_fcs_frame(11);
        send_frame(15, -1, 1'b0, 1'b1, 1'b0);

        // Good frame followed by one with a flipped payload bit.
        build_fcs_frame(5);
        send_frame(15, -1, 1'b0, 1'b1, 1'b0);
        build_fcs_frame(9);
        frm[10] = frm[10] ^ 8'h04;
        send_frame(15, -1, 1'b0, 1'b1, flip_user);

        // Reset mid-frame: first two bytes already out, no tlast for the rest.
        frm = '{8'hA1, 8'hA2, 8'hA3};
        exp_q.push_back({1'b0, 1'b0, 8'hA1});
        exp_q.push_back({1'b0, 1'b0, 8'hA2});
        for (int p = 0; p < 6; p++) send_nib(1'b1, 1'b0, 4'h5);
        send_nib(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 3; i++) begin
            send_nib(1'b1, 1'b0, frm[i][3:0]);
            send_nib(1'b1, 1'b0, frm[i][7:4]);
        end
        send_nib(1'b1, 1'b0, 4'h4);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", {31'd0, bus.m_tvalid}, 32'h0);
        check("midrst_tlast",  {31'd0, bus.m_tlast}, 32'h0);
        check("midrst_tuser",  {31'd0, bus.m_tuser}, 32'h0);
        check("midrst_tdata",  {24'd0, bus.m_tdata}, 32'h0);
        check("midrst_state",  {30'd0, state}, {30'd0, IDLE});
        @(posedge clk); #1;
        // Release with rx_dv still high: the trailing frame must be dropped.
        rst_n = 1'b1;
        for (int p = 0; p < 6; p++) send_nib(1'b1, 1'b0, 4'h5);
        check("midrst_drop_state", {30'd0, state}, {30'd0, DROP});
        send_nib(1'b1, 1'b0, 4'hD);
        send_nib(1'b1, 1'b0, 4'h1);
        send_nib(1'b1, 1'b0, 4'h1);
        send_nib(1'b1, 1'b0, 4'h2);
        send_nib(1'b1, 1'b0, 4'h2);
        send_nib(1'b0, 1'b0, 4'h0);

        // Recovery after the dropped frame.
        frm = '{8'h7E, 8'h81};
        send_frame(15, -1, 1'b0, 1'b1, 1'b0);

        repeat (10) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
